// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_READ registered read ports, one write port with bypass,
// optional hardwired-zero entry 0 and a reset-time init sweep so storage can map to block RAM.
module register_file_mp #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    NUM_READ   = 2,
  parameter bit                    ZERO_REG   = 1'b1,
  parameter int                    SP_INDEX   = 2,
  parameter logic [DATA_WIDTH-1:0] SP_INIT    = 32'h0110_0000
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             write_enable,
  input  logic [ADDR_WIDTH-1:0]            addr_rd,
  input  logic [DATA_WIDTH-1:0]            data_rd,
  input  logic [NUM_READ-1:0]              read_enable,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]   addr_rs,
  output logic [NUM_READ*DATA_WIDTH-1:0]   data_rs,
  output logic                             init_done,
  output logic                             dbg_state_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Handshake: none. write_enable and read_enable are single-cycle strobes sampled on
  // every rising edge in READY; there is no ready/stall back-pressure in either direction.

  typedef enum logic {S_INIT = 1'b0, S_READY = 1'b1} state_e;

  state_e                         state_q, state_d;
  logic [ADDR_WIDTH-1:0]          cnt_q, cnt_d;
  logic [NUM_READ*DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0]          mem [DEPTH];

  logic                           mem_we;
  logic [ADDR_WIDTH-1:0]          mem_waddr;
  logic [DATA_WIDTH-1:0]          mem_wdata;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) state_d = S_READY;
      end
      default: state_d = S_READY;
    endcase
  end

  // The single physical write port is shared between the init sweep and writeback.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr_rd;
    mem_wdata = data_rd;
    case (state_q)
      S_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = (cnt_q == ADDR_WIDTH'(SP_INDEX)) ? SP_INIT : '0;
      end
      default: begin
        mem_we = write_enable && !(ZERO_REG && (addr_rd == '0));
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    data_d = data_q;
    if (state_q == S_READY) begin
      for (int k = 0; k < NUM_READ; k++) begin
        if (read_enable[k]) begin
          if (ZERO_REG && (addr_rs[k*ADDR_WIDTH +: ADDR_WIDTH] == '0))
            data_d[k*DATA_WIDTH +: DATA_WIDTH] = '0;
          else if (mem_we && (addr_rd == addr_rs[k*ADDR_WIDTH +: ADDR_WIDTH]))
            data_d[k*DATA_WIDTH +: DATA_WIDTH] = data_rd;
          else
            data_d[k*DATA_WIDTH +: DATA_WIDTH] = mem[addr_rs[k*ADDR_WIDTH +: ADDR_WIDTH]];
        end
      end
    end
  end

  assign data_rs     = data_q;
  assign init_done   = (state_q == S_READY);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: a ZERO_REG=1 and a ZERO_REG=0 instance share stimulus and
// are compared every cycle against an array-based model of the register file.
module tb_register_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;
  localparam logic [DW-1:0] SP_VAL = 32'h0110_0000;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          write_enable = 1'b0;
  logic [AW-1:0] addr_rd = '0;
  logic [DW-1:0] data_rd = '0;
  logic [NR-1:0] read_enable = '0;
  logic [NR*AW-1:0] addr_rs = '0;
  logic [NR*DW-1:0] data_rs_z, data_rs_n;
  logic          init_done_z, init_done_n, dbg_z, dbg_n;

  int chk_cnt = 0;
  int pass_cnt = 0;

  logic [DW-1:0] mem_m [2][DEPTH];
  logic [DW-1:0] rs_m  [2][NR];
  bit            ready_m;
  int            cyc_m;

  always #5 clock = ~clock;

  register_file_mp #(.ZERO_REG(1'b1)) dut_z (
    .clock(clock), .reset_n(reset_n), .write_enable(write_enable), .addr_rd(addr_rd),
    .data_rd(data_rd), .read_enable(read_enable), .addr_rs(addr_rs),
    .data_rs(data_rs_z), .init_done(init_done_z), .dbg_state_o(dbg_z));

  register_file_mp #(.ZERO_REG(1'b0)) dut_n (
    .clock(clock), .reset_n(reset_n), .write_enable(write_enable), .addr_rd(addr_rd),
    .data_rd(data_rd), .read_enable(read_enable), .addr_rs(addr_rs),
    .data_rs(data_rs_n), .init_done(init_done_n), .dbg_state_o(dbg_n));

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
  endtask

  // Reference: after DEPTH post-reset edges the array holds its init image; before that
  // nothing is visible. Zero-register behaviour is applied to instance 0 only.
  task automatic model_edge();
    logic [AW-1:0] ra;
    bit zr, wr_ok;
    if (!ready_m) begin
      cyc_m++;
      if (cyc_m == DEPTH) begin
        ready_m = 1'b1;
        for (int d = 0; d < 2; d++)
          for (int e = 0; e < DEPTH; e++) mem_m[d][e] = (e == 2) ? SP_VAL : '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        zr = (d == 0);
        wr_ok = write_enable && !(zr && addr_rd == 0);
        for (int k = 0; k < NR; k++) begin
          if (read_enable[k]) begin
            ra = addr_rs[k*AW +: AW];
            if (zr && ra == 0)                rs_m[d][k] = '0;
            else if (wr_ok && addr_rd == ra)  rs_m[d][k] = data_rd;
            else                              rs_m[d][k] = mem_m[d][ra];
          end
        end
        if (wr_ok) mem_m[d][addr_rd] = data_rd;
      end
    end
  endtask

  task automatic compare_all();
    check("rs0_z", data_rs_z[0 +: DW], rs_m[0][0]);
    check("rs1_z", data_rs_z[DW +: DW], rs_m[0][1]);
    check("rs0_n", data_rs_n[0 +: DW], rs_m[1][0]);
    check("rs1_n", data_rs_n[DW +: DW], rs_m[1][1]);
    check("init_done_z", {31'b0, init_done_z}, {31'b0, ready_m});
    check("init_done_n", {31'b0, init_done_n}, {31'b0, ready_m});
  endtask

  // Called at a negedge: applies inputs, advances one clock, checks #1 after the edge.
  task automatic drive(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [NR-1:0] re, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    write_enable = we; addr_rd = wa; data_rd = wd; read_enable = re; addr_rs = {ra1, ra0};
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
    @(negedge clock);
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, '0, '0);
  endtask

  task automatic rand_cycle();
    drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), $urandom,
          NR'($urandom_range(0, 3)), AW'($urandom_range(0, DEPTH - 1)),
          AW'($urandom_range(0, DEPTH - 1)));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    ready_m = 1'b0; cyc_m = 0;
    for (int d = 0; d < 2; d++) for (int k = 0; k < NR; k++) rs_m[d][k] = '0;
    #1;
    compare_all();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic wait_init();
    int n = 0;
    while (!init_done_z && n < 100) begin
      rand_cycle();
      n++;
    end
    check("init_latency", DW'(n), DW'(DEPTH));
  endtask

  initial begin
    @(negedge clock);
    do_reset();
    wait_init();

    for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, '0, 2'b01, AW'(i), '0);
    check("sp_init", data_rs_z[0 +: DW], 32'h0);
    drive(1'b0, '0, '0, 2'b01, 5'd2, '0);
    check("sp_value", data_rs_z[0 +: DW], SP_VAL);

    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 2'b00, '0, '0);
    drive(1'b0, '0, '0, 2'b10, '0, 5'd5);
    check("wr_rd_x5", data_rs_z[DW +: DW], 32'hDEAD_BEEF);

    drive(1'b1, 5'd8, 32'hA5A5_0008, 2'b00, '0, '0);
    drive(1'b1, 5'd7, 32'h1234_5678, 2'b11, 5'd7, 5'd8);
    check("bypass_x7", data_rs_z[0 +: DW], 32'h1234_5678);
    check("old_x8", data_rs_z[DW +: DW], 32'hA5A5_0008);
    drive(1'b1, 5'd7, 32'h0BAD_F00D, 2'b11, 5'd7, 5'd7);
    check("bypass_p0", data_rs_z[0 +: DW], 32'h0BAD_F00D);
    check("bypass_p1", data_rs_z[DW +: DW], 32'h0BAD_F00D);

    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 2'b01, 5'd0, '0);
    check("x0_conc_z", data_rs_z[0 +: DW], 32'h0);
    check("x0_conc_n", data_rs_n[0 +: DW], 32'hFFFF_FFFF);
    drive(1'b0, '0, '0, 2'b10, '0, 5'd0);
    check("x0_read_z", data_rs_z[DW +: DW], 32'h0);
    check("x0_read_n", data_rs_n[DW +: DW], 32'hFFFF_FFFF);

    for (int i = 0; i < 8; i++)
      drive(1'($urandom_range(0, 1)), AW'($urandom_range(1, DEPTH - 1)), $urandom, 2'b00,
            AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(0, DEPTH - 1)));
    check("hold_x0_n", data_rs_n[DW +: DW], 32'hFFFF_FFFF);

    for (int i = 0; i < 400; i++) rand_cycle();

    drive(1'b1, 5'd5, 32'hCAFE_0005, 2'b00, '0, '0);
    do_reset();
    for (int i = 0; i < 10; i++) rand_cycle();
    do_reset();
    wait_init();
    drive(1'b0, '0, '0, 2'b11, 5'd5, 5'd2);
    check("x5_after_rst", data_rs_z[0 +: DW], 32'h0);
    check("sp_after_rst", data_rs_z[DW +: DW], SP_VAL);

    for (int i = 0; i < 200; i++) rand_cycle();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
